sdram_cmd_arbiter: RTL
======================

SDRAM_CMD_ARBITER -- requirements
Module: sdram_cmd_arbiter

Interface
REQ-001 Parameter NUM_CH, default 4, number of requester channels (2..8).
REQ-002 Parameter ADDR_W, default 12, SDRAM address bus width.
REQ-003 Parameter BA_W, default 2, bank address width.
REQ-004 Parameter CMD_W, default 4, command width ({cs_n,ras_n,cas_n,we_n}).
REQ-005 Parameter RR_EN, default 1: 1 selects round-robin among non-urgent channels, 0 selects fixed priority (lowest index wins).
REQ-006 Parameter URGENT_MASK, default 4'b0001, marks channels that outrank all others (e.g. auto-refresh).
REQ-007 Parameter PREEMPT_EN, default 1, allows urgent requests to preempt a non-urgent grant.
REQ-008 sys_clk  in  1  single clock; all logic on rising edge.
REQ-009 sys_rst  in  1  reset, synchronous, active-high.
REQ-010 init_done  in  1  SDRAM power-up sequence complete.
REQ-011 init_addr / init_ba / init_cmd  in  ADDR_W / BA_W / CMD_W  init sequencer outputs.
REQ-012 ch_req / ch_end  in  NUM_CH each  per-channel request; per-channel last-command strobe.
REQ-013 ch_addr / ch_ba / ch_cmd  in  NUM_CH*ADDR_W / NUM_CH*BA_W / NUM_CH*CMD_W  flattened per-channel buses, channel i at slice i.
REQ-014 ch_en / ch_wait  out  NUM_CH each  grant (one-hot or zero); preemption request (finish burst and stop).
REQ-015 addro / bao / cmdo  out  ADDR_W / BA_W / CMD_W  registered SDRAM pins.
REQ-016 busy  out  1  high when !init_done or any ch_en or ch_wait set or state is not ARB.

Function
REQ-017 States: INIT, ARB, GRANT, PREEMPT, GAP; encoding in shared package.
REQ-018 INIT: outputs register init_* each cycle; on init_done high, next state ARB.
REQ-019 ARB: outputs NOP (addro all-ones, bao all-ones, cmdo CMD_NOP); any ch_req high -> select winner g, next state GRANT, ch_en[g] asserted from the following cycle.
REQ-020 Selection: any urgent requester beats all non-urgent; within a class, RR_EN=1 searches from (last_grant+1) mod NUM_CH upward with wrap, RR_EN=0 picks lowest index.
REQ-021 last_grant updates only on entry to GRANT; reset value NUM_CH-1 so first round-robin search starts at channel 0.
REQ-022 GRANT: addro/bao/cmdo register channel g slices every cycle, ch_en[g]=1.
REQ-023 GRANT with ch_end[g] high -> ch_en[g] deasserts the next cycle, next state GAP; ch_end[g] has priority over any preemption condition the same cycle.
REQ-024 GRANT, PREEMPT_EN=1, g non-urgent, an urgent ch_req high, ch_end[g] low -> next state PREEMPT.
REQ-025 PREEMPT: ch_en[g]=0, ch_wait[g]=1, channel g commands still muxed to outputs until ch_end[g]; then next state GAP with ch_wait[g] cleared.
REQ-026 GAP: exactly one NOP cycle, all ch_en/ch_wait low, next state ARB; guarantees minimum one-cycle bus turnaround between grants.
REQ-027 ch_end from non-granted channels is ignored; ch_req dropping during GRANT does not end the grant.
REQ-028 Arbitration latency: ch_req high in ARB -> ch_en at +1 cycle, channel command on pins at +2 cycles.
REQ-029 Out-of-range state -> ARB if init_done else INIT, outputs NOP.

Reset
REQ-030 sys_rst high at a clock edge forces, on that edge: state INIT, addro all-ones, bao all-ones, cmdo all-ones, ch_en 0, ch_wait 0, last_grant NUM_CH-1.
REQ-031 Reset mid-grant or mid-preempt abandons the transfer with no further grant until INIT completes again.

Structure
REQ-032 Package sdram_pkg holds the state enum, CMD_NOP (4'b0111), CMD_INHIBIT (4'b1111) and default widths.
REQ-033 One sub-module sdram_rr_pick: combinational masked round-robin/fixed selector (req vector, urgent mask, last_grant -> winner index, valid).

Verification
REQ-034 Init pass-through: init_cmd=4'b0010, init_done=0 -> cmdo=4'b0010 next cycle; init_done=1 -> cmdo=CMD_NOP two cycles later.
REQ-035 Round-robin: ch_req=4'b1110 held, each grant ended after 3 cycles -> grant order 1,2,3,1 with one GAP NOP between grants.
REQ-036 Urgent priority: ch_req=4'b0101 simultaneously in ARB -> ch_en=4'b0001 first, then 4'b0100.
REQ-037 Preemption: ch 2 granted, ch_req[0] rises, ch_end[2] 2 cycles later -> ch_wait[2]=1 for those cycles, GAP, then ch_en[0]=1.
REQ-038 Simultaneous ch_end[2] and urgent ch_req[0] -> no ch_wait, direct GAP then grant to 0.
REQ-039 sys_rst asserted during GRANT -> next edge cmdo=4'b1111, ch_en=0, state INIT.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared types and constants for the SDRAM command arbiter.
package sdram_pkg;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_ADDR_W = 12;
  localparam int DEF_BA_W   = 2;
  localparam int DEF_CMD_W  = 4;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP     = 4'b0111;
  localparam logic [3:0] CMD_INHIBIT = 4'b1111;

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_ARB     = 3'd1,
    ST_GRANT   = 3'd2,
    ST_PREEMPT = 3'd3,
    ST_GAP     = 3'd4
  } state_t;

endpackage

// File: rtl/sdram_rr_pick.sv
// Combinational winner selector: urgent class first, then round-robin
// (starting just past last_grant) or fixed lowest-index priority.
module sdram_rr_pick #(
  parameter int NUM_CH = 4,
  parameter bit RR_EN  = 1'b1
) (
  input  logic [NUM_CH-1:0]         req,
  input  logic [NUM_CH-1:0]         urgent,
  input  logic [$clog2(NUM_CH)-1:0] last_grant,
  output logic [$clog2(NUM_CH)-1:0] idx,
  output logic                      valid
);
  localparam int IDX_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0] urg_req;
  logic [NUM_CH-1:0] cand;

  assign urg_req = req & urgent;
  assign cand    = (|urg_req) ? urg_req : req;
  assign valid   = |req;

  // Walk the candidate set from the search base with wrap; first hit wins.
  always_comb begin
    int               base;
    int               c;
    logic [IDX_W-1:0] ci;
    logic             found;
    idx   = '0;
    found = 1'b0;
    base  = RR_EN ? int'(last_grant) + 1 : 0;
    for (int k = 0; k < NUM_CH; k++) begin
      c  = (base + k) % NUM_CH;
      ci = IDX_W'(c);
      if (!found && cand[ci]) begin
        idx   = ci;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_cmd_arbiter.sv
// Multi-channel SDRAM command arbiter: passes the init sequencer through
// until init_done, then grants one channel at a time onto registered pins,
// with urgent preemption and a one-cycle turnaround gap between grants.
module sdram_cmd_arbiter
  import sdram_pkg::*;
#(
  parameter int                NUM_CH      = DEF_NUM_CH,
  parameter int                ADDR_W      = DEF_ADDR_W,
  parameter int                BA_W        = DEF_BA_W,
  parameter int                CMD_W       = DEF_CMD_W,
  parameter bit                RR_EN       = 1'b1,
  parameter logic [NUM_CH-1:0] URGENT_MASK = NUM_CH'(1),
  parameter bit                PREEMPT_EN  = 1'b1
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic                     init_done,
  input  logic [ADDR_W-1:0]        init_addr,
  input  logic [BA_W-1:0]          init_ba,
  input  logic [CMD_W-1:0]         init_cmd,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH-1:0]        ch_end,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  input  logic [NUM_CH*BA_W-1:0]   ch_ba,
  input  logic [NUM_CH*CMD_W-1:0]  ch_cmd,
  output logic [NUM_CH-1:0]        ch_en,
  output logic [NUM_CH-1:0]        ch_wait,
  output logic [ADDR_W-1:0]        addro,
  output logic [BA_W-1:0]          bao,
  output logic [CMD_W-1:0]         cmdo,
  output logic                     busy
);
  localparam int IDX_W = $clog2(NUM_CH);
  localparam logic [CMD_W-1:0] NOP_C = CMD_W'(CMD_NOP);
  localparam logic [CMD_W-1:0] INH_C = CMD_W'(CMD_INHIBIT);

  state_t state, nxt;
  logic [IDX_W-1:0] last_grant;  // doubles as the current grant index
  logic [IDX_W-1:0] win, gnt_nxt;
  logic             win_vld;
  logic             preempt;

  logic [NUM_CH-1:0][ADDR_W-1:0] ch_addr_a;
  logic [NUM_CH-1:0][BA_W-1:0]   ch_ba_a;
  logic [NUM_CH-1:0][CMD_W-1:0]  ch_cmd_a;

  logic [ADDR_W-1:0] addr_d;
  logic [BA_W-1:0]   ba_d;
  logic [CMD_W-1:0]  cmd_d;
  logic [NUM_CH-1:0] ch_en_d, ch_wait_d;

  assign ch_addr_a = ch_addr;
  assign ch_ba_a   = ch_ba;
  assign ch_cmd_a  = ch_cmd;

  sdram_rr_pick #(
    .NUM_CH (NUM_CH),
    .RR_EN  (RR_EN)
  ) u_pick (
    .req        (ch_req),
    .urgent     (URGENT_MASK),
    .last_grant (last_grant),
    .idx        (win),
    .valid      (win_vld)
  );

  // An urgent requester may only displace a non-urgent owner; ch_end wins.
  assign preempt = PREEMPT_EN && !URGENT_MASK[last_grant]
                   && (|(ch_req & URGENT_MASK)) && !ch_end[last_grant];

  assign busy = !init_done || (|ch_en) || (|ch_wait) || (state != ST_ARB);

  // Next state and the values the pins/grant lines take after this edge.
  always_comb begin
    nxt     = state;
    addr_d  = '1;
    ba_d    = '1;
    cmd_d   = NOP_C;
    gnt_nxt = (state == ST_ARB) ? win : last_grant;
    case (state)
      ST_INIT: begin
        addr_d = init_addr;
        ba_d   = init_ba;
        cmd_d  = init_cmd;
        if (init_done) nxt = ST_ARB;
      end
      ST_ARB: if (win_vld) nxt = ST_GRANT;
      ST_GRANT: begin
        addr_d = ch_addr_a[last_grant];
        ba_d   = ch_ba_a[last_grant];
        cmd_d  = ch_cmd_a[last_grant];
        if (ch_end[last_grant]) nxt = ST_GAP;
        else if (preempt)       nxt = ST_PREEMPT;
      end
      ST_PREEMPT: begin
        addr_d = ch_addr_a[last_grant];
        ba_d   = ch_ba_a[last_grant];
        cmd_d  = ch_cmd_a[last_grant];
        if (ch_end[last_grant]) nxt = ST_GAP;
      end
      ST_GAP: nxt = ST_ARB;
      default: nxt = init_done ? ST_ARB : ST_INIT;
    endcase
    ch_en_d   = (nxt == ST_GRANT)   ? (NUM_CH'(1) << gnt_nxt)    : '0;
    ch_wait_d = (nxt == ST_PREEMPT) ? (NUM_CH'(1) << last_grant) : '0;
  end

  // State, grant bookkeeping and registered SDRAM pins.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state      <= ST_INIT;
      addro      <= '1;
      bao        <= '1;
      cmdo       <= INH_C;
      ch_en      <= '0;
      ch_wait    <= '0;
      last_grant <= IDX_W'(NUM_CH - 1);
    end else begin
      state   <= nxt;
      addro   <= addr_d;
      bao     <= ba_d;
      cmdo    <= cmd_d;
      ch_en   <= ch_en_d;
      ch_wait <= ch_wait_d;
      if (state == ST_ARB && win_vld) last_grant <= win;
    end
  end

endmodule
